// File: rtl/ctrl_pkg.sv
`default_nettype none
// ---- ctrl_pkg : encodings shared by the control decode stage ---- rev 1.0 ----

package ctrl_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_MUL = 4'b1010;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    MUL_BUSY = 2'b10
  } state_t;

  // Control bundle as held in the output register (all-zero is a bubble).
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       s;
    logic       b;
    logic       illegal;
  } ctl_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ---- ctrl_decode : combinational instruction decode table ---- rev 1.0 ----
// ---- optional multiply decode enabled by macro CTRL_DECODE_MUL_EN        ----

module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic       in_valid,
  input  logic [1:0] mode,
  input  logic [3:0] op_code,
  input  logic       s_in,
  output ctl_t       ctl,
  output logic       is_mem
`ifdef CTRL_DECODE_MUL_EN
  ,
  output logic       is_mul
`endif
);

  always_comb begin
    ctl    = '0;
    is_mem = 1'b0;
`ifdef CTRL_DECODE_MUL_EN
    is_mul = 1'b0;
`endif
    if (in_valid) begin
      case (mode)
        MODE_ALU: begin
          ctl.wb_en = 1'b1;
          ctl.s     = s_in;
          case (op_code)
            4'b0000: ctl.exe_cmd = EXE_AND;
            4'b0001: ctl.exe_cmd = EXE_EOR;
            4'b0010: ctl.exe_cmd = EXE_SUB;
            4'b0100: ctl.exe_cmd = EXE_ADD;
            4'b0101: ctl.exe_cmd = EXE_ADC;
            4'b0110: ctl.exe_cmd = EXE_SBC;
            4'b1100: ctl.exe_cmd = EXE_ORR;
            4'b1101: ctl.exe_cmd = EXE_MOV;
            4'b1111: ctl.exe_cmd = EXE_MVN;
            // Compares reuse the AND/SUB datapath but never write back.
            4'b1000: begin
              ctl.exe_cmd = EXE_AND;
              ctl.wb_en   = 1'b0;
            end
            4'b1010: begin
              ctl.exe_cmd = EXE_SUB;
              ctl.wb_en   = 1'b0;
            end
`ifdef CTRL_DECODE_MUL_EN
            4'b0011: begin
              ctl.exe_cmd = EXE_MUL;
              is_mul      = 1'b1;
            end
`endif
            default: begin
              ctl         = '0;
              ctl.illegal = 1'b1;
            end
          endcase
        end
        MODE_MEM: begin
          ctl.exe_cmd = EXE_ADD;
          is_mem      = 1'b1;
          if (s_in) begin
            ctl.mem_r_en = 1'b1;
            ctl.wb_en    = 1'b1;
          end else begin
            ctl.mem_w_en = 1'b1;
          end
        end
        MODE_BR: begin
          ctl.exe_cmd = EXE_NOP;
          ctl.b       = 1'b1;
          ctl.s       = s_in;
        end
        default: ctl.illegal = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_decode_stage.sv
`default_nettype none
// ---- ctrl_decode_stage : ID/EX control register, stall FSM, mul counter ---- rev 1.0 ----
// ---- optional multiply occupancy enabled by macro CTRL_DECODE_MUL_EN         ----

module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int EXE_CMD_W = 4,
  parameter int MUL_LAT   = 4,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           mode,
  input  logic [3:0]           op_code,
  input  logic                 s_in,
  input  logic                 hazard,
  input  logic                 flush,
  input  logic                 mem_ready,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic                 wb_en,
  output logic                 s,
  output logic                 b,
  output logic                 out_valid,
  output logic                 illegal,
  output logic                 stall_out
);

  if (EXE_CMD_W < 4 || MUL_LAT < 2 || MUL_LAT > 15 || (MUL_LAT - 1) >= (1 << CNT_W))
  begin : g_param_check
    $error("ctrl_decode_stage: illegal EXE_CMD_W/MUL_LAT/CNT_W combination");
  end

  ctl_t   dec;
  logic   dec_mem;
  ctl_t   ctl_q, ctl_d;
  logic   valid_q, valid_d;
  state_t state_q, state_d;
  logic   hold;

`ifdef CTRL_DECODE_MUL_EN
  logic             dec_mul;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  ctrl_decode u_decode (
    .in_valid (in_valid),
    .mode     (mode),
    .op_code  (op_code),
    .s_in     (s_in),
    .ctl      (dec),
    .is_mem   (dec_mem)
`ifdef CTRL_DECODE_MUL_EN
    ,
    .is_mul   (dec_mul)
`endif
  );

  // Hold means the instruction in the output register has not finished yet.
  always_comb begin
    hold = 1'b0;
    if (state_q == MEM_WAIT && !mem_ready) hold = 1'b1;
`ifdef CTRL_DECODE_MUL_EN
    if (state_q == MUL_BUSY && cnt_q != '0) hold = 1'b1;
`endif
  end

  assign stall_out = hazard | hold;

  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    valid_d = valid_q;
`ifdef CTRL_DECODE_MUL_EN
    cnt_d   = cnt_q;
`endif
    if (flush) begin
      state_d = RUN;
      ctl_d   = '0;
      valid_d = 1'b0;
`ifdef CTRL_DECODE_MUL_EN
      cnt_d   = '0;
`endif
    end else if (hold) begin
`ifdef CTRL_DECODE_MUL_EN
      if (state_q == MUL_BUSY) cnt_d = cnt_q - 1'b1;
`endif
    end else if (hazard || !in_valid) begin
      // Any pending access has completed here, so a bubble also ends it.
      state_d = RUN;
      ctl_d   = '0;
      valid_d = 1'b0;
    end else begin
      state_d = RUN;
      ctl_d   = dec;
      valid_d = 1'b1;
      if (dec_mem) state_d = MEM_WAIT;
`ifdef CTRL_DECODE_MUL_EN
      if (dec_mul) begin
        state_d = MUL_BUSY;
        cnt_d   = CNT_W'(MUL_LAT - 1);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ctl_q   <= '0;
      valid_q <= 1'b0;
`ifdef CTRL_DECODE_MUL_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      valid_q <= valid_d;
`ifdef CTRL_DECODE_MUL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign exe_cmd   = EXE_CMD_W'(ctl_q.exe_cmd);
  assign mem_r_en  = ctl_q.mem_r_en;
  assign mem_w_en  = ctl_q.mem_w_en;
  assign wb_en     = ctl_q.wb_en;
  assign s         = ctl_q.s;
  assign b         = ctl_q.b;
  assign illegal   = ctl_q.illegal;
  assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_decode_stage.sv
`default_nettype none
// ---- tb_ctrl_decode_stage : directed scoreboard bench for ctrl_decode_stage ---- rev 1.0 ----

module tb_ctrl_decode_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] op_code = 4'b0000;
  logic       s_in = 1'b0;
  logic       hazard = 1'b0;
  logic       flush = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] exe_cmd;
  logic       mem_r_en, mem_w_en, wb_en, s, b, out_valid, illegal, stall_out;

  int checks = 0;
  int failures = 0;
  logic [10:0] sb[$];

  ctrl_decode_stage #(.EXE_CMD_W(4), .MUL_LAT(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mode      (mode),
    .op_code   (op_code),
    .s_in      (s_in),
    .hazard    (hazard),
    .flush     (flush),
    .mem_ready (mem_ready),
    .exe_cmd   (exe_cmd),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .wb_en     (wb_en),
    .s         (s),
    .b         (b),
    .out_valid (out_valid),
    .illegal   (illegal),
    .stall_out (stall_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, out_valid, illegal}
  function automatic logic [10:0] ex(input logic [3:0] e, input logic r, input logic w,
                                     input logic wb, input logic sb_s, input logic br,
                                     input logic v, input logic il);
    return {e, r, w, wb, sb_s, br, v, il};
  endfunction

  function automatic logic [10:0] obs();
    return {exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, out_valid, illegal};
  endfunction

  localparam logic [10:0] BUBBLE = 11'b0;

  task automatic check_stall(input string tag, input logic want);
    checks++;
    assert (stall_out === want) else begin
      failures++;
      $error("FAIL %s stall_out observed=%b expected=%b", tag, stall_out, want);
    end
  endtask

  task automatic check_out(input string tag, input logic [10:0] want);
    checks++;
    assert (obs() === want) else begin
      failures++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs(), want);
    end
  endtask

  // One cycle: drive at negedge, check combinational stall, push expected
  // register contents, then pop and compare just after the rising edge.
  task automatic step(input string tag, input logic v, input logic [1:0] m,
                      input logic [3:0] op, input logic si, input logic hz,
                      input logic fl, input logic mr, input logic want_stall,
                      input logic [10:0] want_out);
    logic [10:0] w;
    @(negedge clk);
    in_valid = v; mode = m; op_code = op; s_in = si;
    hazard = hz; flush = fl; mem_ready = mr;
    #1;
    check_stall(tag, want_stall);
    sb.push_back(want_out);
    @(posedge clk);
    #1;
    w = sb.pop_front();
    check_out(tag, w);
  endtask

  initial begin
    // Reset state, with and without hazard
    #2;
    check_out("reset_outputs", BUBBLE);
    check_stall("reset_stall", 1'b0);
    hazard = 1'b1;
    #1;
    check_stall("reset_stall_hazard", 1'b1);
    hazard = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ALU decode
    step("add",      1, 2'b00, 4'b0100, 1, 0, 0, 0, 0, ex(4'b0010, 0, 0, 1, 1, 0, 1, 0));
    step("mov",      1, 2'b00, 4'b1101, 0, 0, 0, 0, 0, ex(4'b0001, 0, 0, 1, 0, 0, 1, 0));
    step("cmp",      1, 2'b00, 4'b1010, 1, 0, 0, 0, 0, ex(4'b0100, 0, 0, 0, 1, 0, 1, 0));
    step("tst",      1, 2'b00, 4'b1000, 0, 0, 0, 0, 0, ex(4'b0110, 0, 0, 0, 0, 0, 1, 0));
    step("mvn",      1, 2'b00, 4'b1111, 1, 0, 0, 0, 0, ex(4'b1001, 0, 0, 1, 1, 0, 1, 0));
    step("invalid",  0, 2'b01, 4'b1111, 1, 0, 0, 0, 0, BUBBLE);

    // Illegal mode lasts one cycle
    step("illegal",  1, 2'b11, 4'b0100, 1, 0, 0, 0, 0, ex(4'b0000, 0, 0, 0, 0, 0, 1, 1));
    step("after_il", 1, 2'b00, 4'b0000, 0, 0, 0, 0, 0, ex(4'b0110, 0, 0, 1, 0, 0, 1, 0));

    step("branch",   1, 2'b10, 4'b0110, 1, 0, 0, 0, 0, ex(4'b0000, 0, 0, 0, 1, 1, 1, 0));

    // Load with three wait cycles, then next instruction with zero bubble
    step("ldr",      1, 2'b01, 4'b0000, 1, 0, 0, 0, 0, ex(4'b0010, 1, 0, 1, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      step("ldr_wait", 1, 2'b00, 4'b0100, 1, 0, 0, 0, 1, ex(4'b0010, 1, 0, 1, 0, 0, 1, 0));
    step("ldr_done", 1, 2'b00, 4'b0100, 1, 0, 0, 1, 0, ex(4'b0010, 0, 0, 1, 1, 0, 1, 0));

    // Store completing immediately
    step("str",      1, 2'b01, 4'b0000, 0, 0, 0, 0, 0, ex(4'b0010, 0, 1, 0, 0, 0, 1, 0));
    step("str_done", 0, 2'b00, 4'b0000, 0, 0, 0, 1, 0, BUBBLE);

    // Hazard inserts a bubble
    step("hazard",   1, 2'b00, 4'b0100, 1, 1, 0, 0, 1, BUBBLE);

    // Flush during MEM_WAIT returns to RUN
    step("ldr2",     1, 2'b01, 4'b0000, 1, 0, 0, 0, 0, ex(4'b0010, 1, 0, 1, 0, 0, 1, 0));
    step("flush_mw", 1, 2'b00, 4'b0100, 1, 1, 1, 0, 1, BUBBLE);
    step("post_fl",  1, 2'b00, 4'b0100, 0, 0, 0, 0, 0, ex(4'b0010, 0, 0, 1, 0, 0, 1, 0));
    step("flush_run",1, 2'b00, 4'b0100, 1, 0, 1, 0, 0, BUBBLE);

    // Multiply
`ifdef CTRL_DECODE_MUL_EN
    step("mul",      1, 2'b00, 4'b0011, 1, 0, 0, 0, 0, ex(4'b1010, 0, 0, 1, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      step("mul_busy", 1, 2'b00, 4'b1101, 0, 0, 0, 0, 1, ex(4'b1010, 0, 0, 1, 1, 0, 1, 0));
    step("mul_done", 1, 2'b00, 4'b1101, 0, 0, 0, 0, 0, ex(4'b0001, 0, 0, 1, 0, 0, 1, 0));
`else
    step("mul_ill",  1, 2'b00, 4'b0011, 1, 0, 0, 0, 0, ex(4'b0000, 0, 0, 0, 0, 0, 1, 1));
    step("mul_next", 1, 2'b00, 4'b1101, 0, 0, 0, 0, 0, ex(4'b0001, 0, 0, 1, 0, 0, 1, 0));
`endif

    // Asynchronous reset in the middle of a memory wait
    step("ldr3",     1, 2'b01, 4'b0000, 1, 0, 0, 0, 0, ex(4'b0010, 1, 0, 1, 0, 0, 1, 0));
    @(negedge clk);
    in_valid = 1'b1; mode = 2'b00; op_code = 4'b0100; mem_ready = 1'b0;
    #1;
    check_stall("pre_rst_stall", 1'b1);
    rst = 1'b1;
    #1;
    check_out("async_rst_outputs", BUBBLE);
    check_stall("async_rst_stall", 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0, BUBBLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 Parameter EXE_CMD_W, default 4: width of exe_cmd; values below 4 are illegal.
REQ-002 Parameter MUL_LAT, default 4: multiply occupancy in cycles, legal range 2..15.
REQ-003 Parameter CNT_W, default 4: width of the internal occupancy counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  instruction present from IF/ID.
REQ-007 mode  in  2  instruction mode field.
REQ-008 op_code  in  4  opcode field.
REQ-009 s_in  in  1  S bit for mode 00/10; load (1) or store (0) selector for mode 01.
REQ-010 hazard  in  1  data hazard from the hazard unit.
REQ-011 flush  in  1  taken-branch kill.
REQ-012 mem_ready  in  1  memory completed the access currently held at the output.
REQ-013 exe_cmd  out  EXE_CMD_W  registered ALU command, zero-extended.
REQ-014 mem_r_en, mem_w_en, wb_en, s, b  out  1 each  registered controls.
REQ-015 out_valid  out  1  output register holds a real instruction.
REQ-016 illegal  out  1  registered one-cycle flag for an undecodable valid instruction.
REQ-017 stall_out  out  1  combinational; freezes PC and IF/ID when high.

Function
REQ-018 Decode, mode 00: op 0000->0110, 0001->1000, 0010->0100, 0100->0010, 0101->0011, 0110->0101, 1100->0111, 1101->0001, 1111->1001, each with wb_en=1 and s=s_in.
REQ-019 Decode, compare ops (mode 00): op 1000->0110 and 1010->0100, with wb_en=0 and s=s_in.
REQ-020 Mode 01: exe_cmd=0010; s_in=1 -> mem_r_en=1, wb_en=1; s_in=0 -> mem_w_en=1.
REQ-021 Mode 10: b=1, s=s_in, exe_cmd=0000 (never X).
REQ-022 Any other mode/op with in_valid=1: all controls 0, out_valid=1, illegal=1 for one cycle.
REQ-023 FSM states: RUN, MEM_WAIT, MUL_BUSY.
REQ-024 stall_out = hazard | (state==MEM_WAIT & ~mem_ready) | (state==MUL_BUSY & cnt!=0).
REQ-025 RUN, no stall, no flush: decoded controls are captured at the edge with out_valid=in_valid, giving 1-cycle latency.
REQ-026 hazard=1 in RUN: a bubble is captured (all outputs 0, out_valid=0).
REQ-027 Accepting a valid mode-01 instruction moves the FSM to MEM_WAIT.
REQ-028 MEM_WAIT with mem_ready=0: output register holds unchanged.
REQ-029 MEM_WAIT with mem_ready=1: FSM returns to RUN and the current input is accepted at the same edge (zero bubble).
REQ-030 flush has top priority: at the edge, output -> bubble, FSM -> RUN, cnt -> 0, regardless of hazard, mem_ready or state.
REQ-031 Input fields are ignored when in_valid=0: a bubble is captured and the FSM does not change state.

Reset
REQ-032 While rst is high, all outputs and cnt are 0 and the FSM is in RUN, immediately and without waiting for clk.
REQ-033 Reset during MEM_WAIT or MUL_BUSY abandons the operation; no control re-asserts after release.
REQ-034 stall_out is 0 during reset unless hazard=1.

Configuration
REQ-035 Macro CTRL_DECODE_MUL_EN defined:
- mode 00, op 0011 decodes to exe_cmd 1010, wb_en=1, s=s_in.
- Accepting it loads cnt=MUL_LAT-1 and moves the FSM to MUL_BUSY.
- Outputs hold while cnt decrements each cycle; at cnt==0 the FSM returns to RUN and the next input is accepted at that edge.
REQ-036 Macro undefined: op 0011 in mode 00 is illegal per REQ-022; MUL_BUSY and cnt are not synthesised.

Structure
REQ-037 Shared package ctrl_pkg holds:
- exe_cmd constants (MOV..MUL)
- mode constants (MODE_ALU=00, MODE_MEM=01, MODE_BR=10)
- the FSM state enum
REQ-038 The combinational decode table (REQ-018..REQ-022, REQ-035) lives in sub-module ctrl_decode; ctrl_decode_stage contains only the registers, FSM and counter.

Verification
REQ-039 Reset: rst=1 mid-stream -> all outputs 0 and stall_out=0 before the next clk edge.
REQ-040 ADD: mode=00, op=0100, s_in=1, in_valid=1 -> next cycle exe_cmd=0010, wb_en=1, s=1, out_valid=1, stall_out=0.
REQ-041 Load wait: mode=01, s_in=1; mem_ready=0 for 3 cycles then 1 -> mem_r_en=1 held 4 cycles, stall_out=1 for 3 cycles, next instruction appears the following cycle.
REQ-042 Hazard then flush: hazard=1 -> bubble with stall_out=1; flush=1 during MEM_WAIT -> bubble next cycle and state RUN.
REQ-043 Illegal: mode=11, in_valid=1 -> illegal=1 for exactly one cycle, all enables 0.
REQ-044 MUL: CTRL_DECODE_MUL_EN defined, MUL_LAT=4, op=0011 -> exe_cmd=1010 held 4 cycles, stall_out=1 for 3; macro undefined -> illegal=1.
